fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 89 ++++++++
 tb/tb_fifo_rd_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the async FIFO read port into a valid/ready stream via a small prefetch buffer.
// Optional word counter output rd_word_cnt is enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         rclk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            fifo_rd_data,
    input  logic                         fifo_empty,
    input  logic                         fifo_rd_err,
    output logic                         fifo_rd_en,
    output logic [DATA_W-1:0]            m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    input  logic                         flush,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
    output logic                         err_sticky,
    input  logic                         clr_err
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]             rd_word_cnt
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              inflight_q, err_q, err_d;
    logic              push, pop, ovf, wr;

    // Credit counts the word already in flight so the buffer can never be overrun.
    assign fifo_rd_en = !fifo_empty && !flush &&
                        (({1'b0, level_q} + (AW+2)'(inflight_q)) < (AW+2)'(BUF_DEPTH));
    assign m_valid    = state_q != S_EMPTY;
    assign m_data     = mem_q[rd_ptr_q];
    assign buf_level  = level_q;
    assign err_sticky = err_q;
    assign pop        = m_valid && m_ready && !flush;
    assign push       = inflight_q && !flush;
    assign ovf        = push && !pop && level_q == DEPTH;
    assign wr         = push && !ovf;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = flush ? '0 : level_q + (AW+1)'(wr) - (AW+1)'(pop);
        state_d  = level_d == '0 ? S_EMPTY : level_d == DEPTH ? S_FULL : S_PARTIAL;
        err_d    = (fifo_rd_err || ovf) ? 1'b1 : clr_err ? 1'b0 : err_q;
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= fifo_rd_en;
            err_q      <= err_d;
            if (wr) mem_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d       = flush ? '0 : pop ? cnt_q + CNT_W'(1) : cnt_q;
    assign rd_word_cnt = cnt_q;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a queue-based FIFO model and a capturing sink.
module tb_fifo_rd_stream;
    localparam int DW = 32;
`ifdef FIFO_RD_STREAM_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_err = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    buf_level;
    logic          err_sticky;
    logic          clr_err = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CW-1:0] rd_word_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] rx[$];

    fifo_rd_stream #(.DATA_W(DW), .BUF_DEPTH(4), .CNT_W(CW)) dut (
        .rclk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_err(fifo_rd_err), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .flush(flush), .buf_level(buf_level), .err_sticky(err_sticky),
        .clr_err(clr_err)
`ifdef FIFO_RD_STREAM_CNT_EN
        , .rd_word_cnt(rd_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: data appears after the edge that accepts fifo_rd_en.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        total++;
        assert (!(fifo_rd_en && fifo_empty)) else begin
            bad++;
            $error("FAIL rd_when_empty obs=1 exp=0 t=%0t", $time);
        end
        if (fifo_rd_en && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_rd_data <= w;
            fifo_empty   <= (fq.size() == 0);
        end
    end

    always @(posedge clk)
        if (rst_n && m_valid && m_ready && !flush) rx.push_back(m_data);

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk("wait_rx_count", DW'(rx.size()), DW'(n));
    endtask

    initial begin
        // 1: reset
        #1 rst_n = 1'b0;
        #5;
        chk("rst_rd_en", DW'(fifo_rd_en), 0);
        chk("rst_valid", DW'(m_valid), 0);
        chk("rst_level", DW'(buf_level), 0);
        chk("rst_err", DW'(err_sticky), 0);
        chk("rst_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // 2: 24 alternating words, sink always ready
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) load(i % 2 ? 32'h0000_5555 : 32'hffff_aaaa);
        cyc(2);
        chk("stream_startup", DW'(rx.size()), 0);
        cyc(1);
        chk("stream_first", DW'(rx.size()), 1);
        cyc(23);
        chk("stream_rate", DW'(rx.size()), 24);
        for (int i = 0; i < 24 && i < rx.size(); i++)
            chk("stream_word", rx[i], i % 2 ? 32'h0000_5555 : 32'hffff_aaaa);
        cyc(2);
        chk("stream_level_end", DW'(buf_level), 0);
        chk("stream_err", DW'(err_sticky), 0);

        // 3: backpressure fills buffer, one pop refills within 2 cycles
        rx.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) load(32'h100 + i);
        cyc(8);
        chk("bp_level_full", DW'(buf_level), 4);
        chk("bp_rd_en", DW'(fifo_rd_en), 0);
        chk("bp_head", m_data, 32'h100);
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        chk("bp_one_pop", DW'(rx.size()), 1);
        chk("bp_next_head", m_data, 32'h101);
        cyc(2);
        chk("bp_refill", DW'(buf_level), 4);
        m_ready = 1'b1;
        wait_rx(10, 40);
        for (int i = 0; i < 10 && i < rx.size(); i++) chk("bp_word", rx[i], 32'h100 + i);

        // 4: flush while a word is in flight with three buffered
        cyc(2);
        rx.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(32'h200 + i);
        cyc(4);
        chk("fl_level_pre", DW'(buf_level), 3);
        chk("fl_inflight_pre", DW'(dut.inflight_q), 1);
        flush = 1'b1;
        m_ready = 1'b1;
        #1 chk("fl_rd_en_forced", DW'(fifo_rd_en), 0);
        cyc(1);
        flush = 1'b0;
        chk("fl_level", DW'(buf_level), 0);
        chk("fl_valid", DW'(m_valid), 0);
        chk("fl_no_hs", DW'(rx.size()), 0);
        wait_rx(4, 20);
        for (int i = 0; i < 4 && i < rx.size(); i++) chk("fl_word", rx[i], 32'h204 + i);
        cyc(3);
        chk("fl_no_extra", DW'(rx.size()), 4);

        // 5: sticky error, set beats clear
        fifo_rd_err = 1'b1;
        cyc(1);
        fifo_rd_err = 1'b0;
        chk("err_set", DW'(err_sticky), 1);
        cyc(2);
        chk("err_hold", DW'(err_sticky), 1);
        fifo_rd_err = 1'b1;
        clr_err = 1'b1;
        cyc(1);
        fifo_rd_err = 1'b0;
        chk("err_set_wins", DW'(err_sticky), 1);
        cyc(1);
        clr_err = 1'b0;
        chk("err_clear", DW'(err_sticky), 0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // 6: word counter wraps and clears on flush
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("cnt_flush0", DW'(rd_word_cnt), 0);
        rx.delete();
        for (int i = 0; i < 18; i++) load(32'h300 + i);
        wait_rx(18, 40);
        chk("cnt_wrap", DW'(rd_word_cnt), 2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("cnt_flush", DW'(rd_word_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
